// File: rtl/bullet_pool.sv
// bullet_pool: multi-slot player projectile manager.
// Spawns bullets on fire edges (with cooldown) and moves them upward on a
// shared rate tick. It resolves hits against a single square enemy and
// reports a hit pulse, a saturating hit count and the enemy colour.
module bullet_pool #(
  parameter int NUM_BULLETS = 4,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int RATE_DIV    = 500000,
  parameter int STEP        = 1,
  parameter int COOLDOWN    = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play,
  input  logic                       load_level,
  input  logic                       fire,
  input  logic [X_W-1:0]             playerX,
  input  logic [Y_W-1:0]             playerY,
  input  logic [X_W-1:0]             enemyX,
  input  logic [Y_W-1:0]             enemyY,
  input  logic [2:0]                 enemy_width,
  output logic [NUM_BULLETS-1:0]     bullet_active,
  output logic [NUM_BULLETS*X_W-1:0] bulletX,
  output logic [NUM_BULLETS*Y_W-1:0] bulletY,
  output logic                       move,
  output logic                       enemy_hit,
  output logic [7:0]                 hit_count,
  output logic [2:0]                 enemy_color
);

  localparam int              CNT_W    = $clog2(RATE_DIV);
  localparam int              CD_W     = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(COOLDOWN);
  localparam logic [Y_W-1:0]   STEP_Y   = Y_W'(STEP);

  // State registers
  logic [NUM_BULLETS-1:0] r_active;
  logic [X_W-1:0]         r_x [NUM_BULLETS];
  logic [Y_W-1:0]         r_y [NUM_BULLETS];
  logic [CNT_W-1:0]       r_cnt;
  logic [CD_W-1:0]        r_cd;
  logic                   r_fire_d;
  logic                   r_move;
  logic                   r_hit;
  logic [7:0]             r_hit_count;
  logic [2:0]             r_color;

  // Combinational signals
  logic [X_W:0]           w_spawn_sum;
  logic [X_W-1:0]         w_spawn_x;
  logic [Y_W-1:0]         w_spawn_y;
  logic                   w_tick;
  logic                   w_fire_edge;
  logic [X_W:0]           w_ex_hi;
  logic [Y_W:0]           w_ey_hi;
  logic [NUM_BULLETS-1:0] w_col;
  logic                   w_any_col;
  logic [NUM_BULLETS-1:0] w_free_sel;
  logic                   w_free_found;
  logic                   w_accept;
  logic [NUM_BULLETS-1:0] w_active_nxt;
  logic [X_W-1:0]         w_x_nxt [NUM_BULLETS];
  logic [Y_W-1:0]         w_y_nxt [NUM_BULLETS];

  // Spawn point sits one pixel right of the player, clamped at the right edge.
  assign w_spawn_sum = {1'b0, playerX} + (X_W+1)'(1);
  assign w_spawn_x   = w_spawn_sum[X_W] ? {X_W{1'b1}} : w_spawn_sum[X_W-1:0];
  assign w_spawn_y   = playerY;

  assign w_tick      = play && (r_cnt == CNT_LAST);
  assign w_fire_edge = fire && !r_fire_d;

  // Inclusive upper corners of the enemy box, one bit wider so they never wrap.
  assign w_ex_hi = {1'b0, enemyX} + (X_W+1)'(enemy_width) - (X_W+1)'(1);
  assign w_ey_hi = {1'b0, enemyY} + (Y_W+1)'(enemy_width) - (Y_W+1)'(1);

  // Per-slot collision test against the enemy box on current registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    w_col = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      w_col[i] = play && r_active[i] && (enemy_width != 3'd0) &&
                 ({1'b0, r_x[i]} >= {1'b0, enemyX}) && ({1'b0, r_x[i]} <= w_ex_hi) &&
                 ({1'b0, r_y[i]} >= {1'b0, enemyY}) && ({1'b0, r_y[i]} <= w_ey_hi);
    end
  end

  assign w_any_col = |w_col;

  // Lowest-index free slot picker.
  always_comb begin
    w_free_sel   = '0;
    w_free_found = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!r_active[i] && !w_free_found) begin
        w_free_sel[i] = 1'b1;
        w_free_found  = 1'b1;
      end
    end
  end

  assign w_accept = play && w_fire_edge && (r_cd == '0) && w_free_found;

  // Next slot state: collision beats movement; a fresh spawn is left alone this cycle.
  always_comb begin
    w_active_nxt = r_active;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      w_x_nxt[i] = r_x[i];
      w_y_nxt[i] = r_y[i];
      if (!r_active[i]) begin
        w_x_nxt[i] = w_spawn_x;
        w_y_nxt[i] = w_spawn_y;
        if (w_accept && w_free_sel[i]) begin
          w_active_nxt[i] = 1'b1;
        end
      end else if (w_col[i]) begin
        w_active_nxt[i] = 1'b0;
      end else if (w_tick) begin
        if (r_y[i] < STEP_Y) begin
          w_active_nxt[i] = 1'b0;
        end else begin
          w_y_nxt[i] = r_y[i] - STEP_Y;
        end
      end
    end
  end

  // Control state: activity flags, tick divider, cooldown, fire edge, hit bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_active    <= '0;
      r_cnt       <= '0;
      r_cd        <= '0;
      r_fire_d    <= 1'b0;
      r_move      <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_count <= 8'd0;
      r_color     <= 3'b111;
    end else if (load_level) begin
      r_active    <= '0;
      r_cnt       <= '0;
      r_cd        <= '0;
      r_fire_d    <= 1'b0;
      r_move      <= 1'b0;
      r_hit       <= 1'b0;
      r_hit_count <= 8'd0;
      r_color     <= 3'b111;
    end else begin
      r_fire_d <= fire;
      r_active <= w_active_nxt;
      if (play) begin
        r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_cd <= CD_LOAD;
      end else if (w_tick && (r_cd != '0)) begin
        r_cd <= r_cd - CD_W'(1);
      end
      r_move <= w_tick && (|r_active);
      r_hit  <= w_any_col;
      if (w_any_col) begin
        if (r_hit_count != 8'hFF) r_hit_count <= r_hit_count + 8'd1;
        if (r_color != 3'd0)      r_color     <= r_color - 3'd1;
      end
    end
  end

  // Slot coordinates: inactive slots follow the spawn point, active ones fly.
  always_ff @(posedge clk) begin
    // NOTE: coordinate registers carry no reset; an inactive slot shows the live spawn point instead.
    for (int i = 0; i < NUM_BULLETS; i++) begin
      r_x[i] <= w_x_nxt[i];
      r_y[i] <= w_y_nxt[i];
    end
  end

  // Output packing; inactive slots present the spawn point directly.
  always_comb begin
    bulletX = '0;
    bulletY = '0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      bulletX[i*X_W +: X_W] = r_active[i] ? r_x[i] : w_spawn_x;
      bulletY[i*Y_W +: Y_W] = r_active[i] ? r_y[i] : w_spawn_y;
    end
  end

  assign bullet_active = r_active;
  assign move          = r_move;
  assign enemy_hit     = r_hit;
  assign hit_count     = r_hit_count;
  assign enemy_color   = r_color;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed testbench for bullet_pool with RATE_DIV=4, COOLDOWN=3, STEP=1.
module tb_bullet_pool;

  localparam int NB = 4;
  localparam int XW = 8;
  localparam int YW = 7;

  logic             clk;
  logic             reset;
  logic             play;
  logic             load_level;
  logic             fire;
  logic [XW-1:0]    playerX;
  logic [YW-1:0]    playerY;
  logic [XW-1:0]    enemyX;
  logic [YW-1:0]    enemyY;
  logic [2:0]       enemy_width;
  logic [NB-1:0]    bullet_active;
  logic [NB*XW-1:0] bulletX;
  logic [NB*YW-1:0] bulletY;
  logic             move;
  logic             enemy_hit;
  logic [7:0]       hit_count;
  logic [2:0]       enemy_color;

  int checks   = 0;
  int failures = 0;
  int mv;

  bullet_pool #(
    .NUM_BULLETS(NB), .X_W(XW), .Y_W(YW), .RATE_DIV(4), .STEP(1), .COOLDOWN(3)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .load_level(load_level), .fire(fire),
    .playerX(playerX), .playerY(playerY), .enemyX(enemyX), .enemyY(enemyY),
    .enemy_width(enemy_width), .bullet_active(bullet_active), .bulletX(bulletX),
    .bulletY(bulletY), .move(move), .enemy_hit(enemy_hit), .hit_count(hit_count),
    .enemy_color(enemy_color)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] by(input int i);
    return 32'(bulletY[i*YW +: YW]);
  endfunction

  function automatic logic [31:0] bx(input int i);
    return 32'(bulletX[i*XW +: XW]);
  endfunction

  initial begin
    reset = 1'b1; play = 1'b0; load_level = 1'b0; fire = 1'b0;
    playerX = 8'd80; playerY = 7'd115;
    enemyX = '0; enemyY = '0; enemy_width = 3'd0;
    #1;
    check("rst_active", 32'(bullet_active), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_color", 32'(enemy_color), 32'd7);
    check("rst_move", 32'(move), 32'd0);
    check("rst_spawn_x", bx(0), 32'd81);
    check("rst_spawn_y", by(0), 32'd115);
    playerX = 8'd255;
    #1;
    check("spawn_x_sat", bx(2), 32'd255);
    playerX = 8'd80;
    @(posedge clk); #1;
    reset = 1'b0;

    // Single shot: spawn at E1, first tick at E4.
    play = 1'b1; fire = 1'b1;
    step(1);                                   // E1
    check("spawn_active", 32'(bullet_active), 32'h1);
    check("spawn_x0", bx(0), 32'd81);
    check("spawn_y0", by(0), 32'd115);
    check("spawn_no_move", 32'(move), 32'd0);
    step(3);                                   // E4
    check("hold_no_repeat", 32'(bullet_active), 32'h1);
    check("tick_y0", by(0), 32'd114);
    check("tick_move", 32'(move), 32'd1);
    fire = 1'b0;
    step(1);                                   // E5
    check("move_pulse_end", 32'(move), 32'd0);
    fire = 1'b1;
    step(1);                                   // E6: cooldown still 2
    check("cooldown_drop", 32'(bullet_active), 32'h1);
    fire = 1'b0;
    step(6);                                   // E12
    check("y0_e12", by(0), 32'd112);
    check("move_e12", 32'(move), 32'd1);

    // Fill the remaining slots, spaced past the cooldown.
    fire = 1'b1; step(1); fire = 1'b0;         // E13
    check("slot1_active", 32'(bullet_active), 32'h3);
    check("slot1_y", by(1), 32'd115);
    step(11);
    fire = 1'b1; step(1); fire = 1'b0;         // E25
    check("slot2_active", 32'(bullet_active), 32'h7);
    step(11);
    fire = 1'b1; step(1); fire = 1'b0;         // E37
    check("slot3_active", 32'(bullet_active), 32'hF);
    step(11);
    fire = 1'b1; step(1); fire = 1'b0;         // E49: pool full
    check("fifth_drop", 32'(bullet_active), 32'hF);
    check("full_y0", by(0), 32'd103);
    check("full_y1", by(1), 32'd106);
    check("full_y2", by(2), 32'd109);
    check("full_y3", by(3), 32'd112);
    check("full_x3", bx(3), 32'd81);
    step(1);                                   // E50, divider at 2

    // Freeze for 20 cycles with a fire edge.
    play = 1'b0; fire = 1'b1; mv = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      fire = 1'b0;
      if (move) mv++;
    end
    check("freeze_move", 32'(mv), 32'd0);
    check("freeze_active", 32'(bullet_active), 32'hF);
    check("freeze_y0", by(0), 32'd103);
    check("freeze_y3", by(3), 32'd112);
    play = 1'b1;
    step(1);                                   // F1: divider 2->3
    check("resume_hold_y0", by(0), 32'd103);
    step(1);                                   // F2: tick
    check("resume_tick_y0", by(0), 32'd102);
    check("resume_tick_y3", by(3), 32'd111);
    check("resume_move", 32'(move), 32'd1);

    // Slot 0 climbs to y=0, then leaves on the next tick.
    step(408);                                 // F410
    check("top_y0", by(0), 32'd0);
    check("top_active", 32'(bullet_active), 32'hF);
    step(4);                                   // F414
    check("offscreen_active", 32'(bullet_active), 32'hE);
    check("offscreen_y1", by(1), 32'd2);
    check("offscreen_y0_spawn", by(0), 32'd115);
    fire = 1'b1; step(1); fire = 1'b0;         // F415
    check("reuse_active", 32'(bullet_active), 32'hF);
    check("reuse_y0", by(0), 32'd115);

    // Clear, then climb into enemy box (80,100) size 4.
    load_level = 1'b1; step(1); load_level = 1'b0; // G0
    check("clear_active", 32'(bullet_active), 32'h0);
    enemyX = 8'd80; enemyY = 7'd100; enemy_width = 3'd4;
    fire = 1'b1; step(1); fire = 1'b0;         // G1
    step(47);                                  // G48
    check("pre_hit_y0", by(0), 32'd103);
    check("pre_hit_active", 32'(bullet_active), 32'h1);
    check("pre_hit_pulse", 32'(enemy_hit), 32'd0);
    step(1);                                   // G49
    check("hit_pulse", 32'(enemy_hit), 32'd1);
    check("hit_count1", 32'(hit_count), 32'd1);
    check("hit_color6", 32'(enemy_color), 32'd6);
    check("hit_active", 32'(bullet_active), 32'h0);
    step(1);
    check("hit_pulse_end", 32'(enemy_hit), 32'd0);

    // Enemy over the spawn point: each shot hits one cycle after spawning.
    enemyY = 7'd112;
    for (int i = 0; i < 7; i++) begin
      fire = 1'b1; step(1); fire = 1'b0; step(1);
      check("sat_hit", 32'(enemy_hit), 32'd1);
      check("sat_count", 32'(hit_count), 32'(2 + i));
      check("sat_color", 32'(enemy_color), (5 - i < 0) ? 32'd0 : 32'(5 - i));
      step(12);
    end

    // Two slots inside the box on the same cycle count once.
    enemy_width = 3'd0;
    fire = 1'b1; step(1); fire = 1'b0;         // J1
    step(13);
    fire = 1'b1; step(1); fire = 1'b0;         // J15
    check("dual_pre_active", 32'(bullet_active), 32'h3);
    enemyY = 7'd109; enemy_width = 3'd7;
    step(1);                                   // J16
    check("dual_active", 32'(bullet_active), 32'h0);
    check("dual_count", 32'(hit_count), 32'd9);
    check("dual_pulse", 32'(enemy_hit), 32'd1);
    check("dual_color", 32'(enemy_color), 32'd0);
    step(1);
    check("dual_pulse_end", 32'(enemy_hit), 32'd0);

    // load_level mid-flight takes effect at the next edge.
    enemy_width = 3'd0;
    step(12);
    fire = 1'b1; step(1); fire = 1'b0;
    check("ll_pre_active", 32'(bullet_active), 32'h1);
    load_level = 1'b1;
    #1;
    check("ll_pre_count", 32'(hit_count), 32'd9);
    step(1);
    load_level = 1'b0;
    check("ll_active", 32'(bullet_active), 32'h0);
    check("ll_count", 32'(hit_count), 32'd0);
    check("ll_color", 32'(enemy_color), 32'd7);

    // Async reset mid-flight takes effect immediately.
    enemyY = 7'd112; enemy_width = 3'd4;
    fire = 1'b1; step(1); fire = 1'b0; step(1);
    check("ar_pre_count", 32'(hit_count), 32'd1);
    enemy_width = 3'd0;
    step(13);
    fire = 1'b1; step(1); fire = 1'b0;
    check("ar_pre_active", 32'(bullet_active), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_active", 32'(bullet_active), 32'h0);
    check("ar_count", 32'(hit_count), 32'd0);
    check("ar_color", 32'(enemy_color), 32'd7);
    check("ar_y0", by(0), 32'd115);
    step(1);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
